// File: rtl/uart_rx.sv
// UART receiver: start bit, 8 data bits MSB first, optional parity, one or two stop bits.
// Define UART_RX_PARITY_EN to build the parity state and checker; otherwise PARITY_ERR is tied low.
module uart_rx (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] MODOS_DE_OPERACAO,
    input  logic       RX_IN,
    output logic [7:0] DATA,
    output logic       DATA_VALID,
    output logic       PARITY_ERR,
    output logic       FRAME_ERR,
    output logic       RTS
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP1  = 3'd4,
        S_STOP2  = 3'd5,
        S_DONE   = 3'd6,
        S_BREAK  = 3'd7
    } state_t;

    state_t      state_q, state_d;
    logic        sync1_q, sync2_q;
    logic        rx_s;
    logic [15:0] div_s, half_s;
    logic [15:0] cnt_q, cnt_d;
    logic        sample_s;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        ferr_q, ferr_d;
    logic        frame_err_q, frame_err_d;
    logic        data_valid_q, data_valid_d;
    logic        rts_q, rts_d;
    logic        unused_mode_s;

`ifdef UART_RX_PARITY_EN
    logic        perr_q, perr_d;
    logic        parity_err_q, parity_err_d;

    function automatic logic parity_calc(input logic [7:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    assign unused_mode_s = ^MODOS_DE_OPERACAO[4:2];
`else
    assign unused_mode_s = ^{MODOS_DE_OPERACAO[4:2], MODOS_DE_OPERACAO[1:0]};
`endif

    assign rx_s = sync2_q;

    // Two-flop synchronizer for the asynchronous serial line (idles high).
    always_ff @(posedge Clock) begin
        if (Reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= RX_IN;
            sync2_q <= sync1_q;
        end
    end

    // Baud divider selection from the operating-mode word.
    always_comb begin
        case (MODOS_DE_OPERACAO[7:6])
            2'b00:   div_s = 16'd10416;
            2'b01:   div_s = 16'd5208;
            2'b10:   div_s = 16'd2604;
            default: div_s = 16'd868;
        endcase
    end

    assign half_s = {1'b0, div_s[15:1]};
    // >= rather than == keeps the counter bounded if the mode changes mid-frame.
    assign sample_s = (cnt_q >= div_s);

    // Next-state, datapath and output computation for the receive FSM.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 16'd1;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        data_d       = data_q;
        ferr_d       = ferr_q;
        frame_err_d  = frame_err_q;
        data_valid_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d       = perr_q;
        parity_err_d = parity_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = 16'd0;
                if (!rx_s) begin
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (cnt_q >= half_s) begin
                    cnt_d = 16'd0;
                    if (rx_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_DATA;
                        bit_idx_d = 3'd7;
                        ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
                        perr_d    = 1'b0;
`endif
                    end
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                if (sample_s) begin
                    cnt_d              = 16'd0;
                    shift_d[bit_idx_q] = rx_s;
                    if (bit_idx_q == 3'd0) begin
`ifdef UART_RX_PARITY_EN
                        if (MODOS_DE_OPERACAO[0]) begin
                            state_d = S_PARITY;
                        end else begin
                            state_d = S_STOP1;
                        end
`else
                        state_d = S_STOP1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q - 3'd1;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (sample_s) begin
                    cnt_d   = 16'd0;
                    perr_d  = (parity_calc(shift_q, MODOS_DE_OPERACAO[1]) != rx_s);
                    state_d = S_STOP1;
                end else begin
                    state_d = S_PARITY;
                end
            end
`endif
            S_STOP1: begin
                if (sample_s) begin
                    cnt_d = 16'd0;
                    if (!rx_s) begin
                        ferr_d = 1'b1;
                    end else begin
                        ferr_d = ferr_q;
                    end
                    if (!MODOS_DE_OPERACAO[5]) begin
                        state_d = S_STOP2;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    state_d = S_STOP1;
                end
            end
            S_STOP2: begin
                if (sample_s) begin
                    cnt_d   = 16'd0;
                    state_d = S_DONE;
                    if (!rx_s) begin
                        ferr_d = 1'b1;
                    end else begin
                        ferr_d = ferr_q;
                    end
                end else begin
                    state_d = S_STOP2;
                end
            end
            S_DONE: begin
                cnt_d        = 16'd0;
                data_d       = shift_q;
                frame_err_d  = ferr_q;
                data_valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                parity_err_d = perr_q;
`endif
                // A stop bit seen low may be a held break; wait for the line to recover.
                if (ferr_q) begin
                    state_d = S_BREAK;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BREAK: begin
                cnt_d = 16'd0;
                if (rx_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_BREAK;
                end
            end
            default: begin
                cnt_d   = 16'd0;
                state_d = S_IDLE;
            end
        endcase
        rts_d = (state_d == S_IDLE);
    end

    // State and output registers; Reset aborts any frame in progress.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 16'd0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'h00;
            data_q       <= 8'h00;
            ferr_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            data_valid_q <= 1'b0;
            rts_q        <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q       <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            ferr_q       <= ferr_d;
            frame_err_q  <= frame_err_d;
            data_valid_q <= data_valid_d;
            rts_q        <= rts_d;
`ifdef UART_RX_PARITY_EN
            perr_q       <= perr_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign DATA       = data_q;
    assign DATA_VALID = data_valid_q;
    assign FRAME_ERR  = frame_err_q;
    assign RTS        = rts_q;
`ifdef UART_RX_PARITY_EN
    assign PARITY_ERR = parity_err_q;
`else
    assign PARITY_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of frames plus hand-written break, glitch and reset sequences.
module tb_uart_rx;

`ifdef UART_RX_PARITY_EN
    localparam bit PAR_BUILD = 1'b1;
`else
    localparam bit PAR_BUILD = 1'b0;
`endif

    logic       Clock;
    logic       Reset;
    logic [7:0] mode;
    logic       RX_IN;
    logic [7:0] DATA;
    logic       DATA_VALID;
    logic       PARITY_ERR;
    logic       FRAME_ERR;
    logic       RTS;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int vcount = 0;
    int vcyc   = 0;

    typedef struct {
        logic [7:0] mode;
        logic [7:0] byte_v;
        logic       flip;
        logic       bad_stop;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
        logic       exp_rts;
    } vec_t;

    vec_t vecs [4];

    uart_rx dut (
        .Clock             (Clock),
        .Reset             (Reset),
        .MODOS_DE_OPERACAO (mode),
        .RX_IN             (RX_IN),
        .DATA              (DATA),
        .DATA_VALID        (DATA_VALID),
        .PARITY_ERR        (PARITY_ERR),
        .FRAME_ERR         (FRAME_ERR),
        .RTS               (RTS)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    always @(negedge Clock) begin
        if (DATA_VALID) begin
            vcount <= vcount + 1;
            vcyc   <= cyc;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int div_of(input logic [7:0] m);
        case (m[7:6])
            2'b00:   return 10416;
            2'b01:   return 5208;
            2'b10:   return 2604;
            default: return 868;
        endcase
    endfunction

    // Cycles from the RX_IN fall to the cycle DATA_VALID is high: 3 to reach T0, then 1+HALF+n*BIT+1.
    function automatic int exp_lat(input logic [7:0] m);
        int d;
        int nb;
        d  = div_of(m);
        nb = 8 + ((PAR_BUILD && m[0]) ? 1 : 0) + (m[5] ? 1 : 2);
        return 5 + d / 2 + nb * (d + 1);
    endfunction

    task automatic send_frame(input logic [7:0] m, input logic [7:0] b, input logic flip,
                              input logic bad_stop, output int fall_c, output logic rts_mid);
        int bitp;
        mode = m;
        bitp = div_of(m) + 1;
        @(negedge Clock);
        fall_c = cyc;
        RX_IN  = 1'b0;
        repeat (bitp) @(negedge Clock);
        rts_mid = RTS;
        for (int i = 7; i >= 0; i--) begin
            RX_IN = b[i];
            repeat (bitp) @(negedge Clock);
        end
        if (PAR_BUILD && m[0]) begin
            RX_IN = (^b) ^ m[1] ^ flip;
            repeat (bitp) @(negedge Clock);
        end
        RX_IN = 1'b1;
        repeat (bitp) @(negedge Clock);
        if (!m[5]) begin
            RX_IN = bad_stop ? 1'b0 : 1'b1;
            repeat (bitp) @(negedge Clock);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int   fall_c;
        logic rts_mid;
        int   v0;
        v0 = vcount;
        send_frame(v.mode, v.byte_v, v.flip, v.bad_stop, fall_c, rts_mid);
        repeat (20) @(negedge Clock);
        chk({tag, "_valid_count"}, vcount - v0, 1);
        chk({tag, "_latency"}, vcyc - fall_c, exp_lat(v.mode));
        chk({tag, "_data"}, DATA, v.exp_data);
        chk({tag, "_parity_err"}, PARITY_ERR, v.exp_perr);
        chk({tag, "_frame_err"}, FRAME_ERR, v.exp_ferr);
        chk({tag, "_rts_mid"}, rts_mid, 0);
        chk({tag, "_rts_after"}, RTS, v.exp_rts);
        chk({tag, "_valid_low"}, DATA_VALID, 0);
    endtask

    initial begin
        int   v0;
        vec_t fe;
        vec_t v5a;

        // mode, byte, flip parity, bad 2nd stop, exp data, exp perr, exp ferr, exp rts
        vecs[0] = '{8'hB5, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{8'hF5, 8'h01, 1'b1, 1'b0, 8'h01, PAR_BUILD, 1'b0, 1'b1};
        vecs[2] = '{8'hF5, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{(PAR_BUILD ? 8'hF4 : 8'hF5), 8'hC3, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b1};
        fe      = '{8'hD5, 8'h80, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0};
        v5a     = '{8'hF5, 8'h5A, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b1};

        Reset = 1'b1;
        RX_IN = 1'b1;
        mode  = 8'hB5;
        repeat (4) @(negedge Clock);
        chk("reset_data", DATA, 8'h00);
        chk("reset_valid", DATA_VALID, 0);
        chk("reset_parity_err", PARITY_ERR, 0);
        chk("reset_frame_err", FRAME_ERR, 0);
        chk("reset_rts", RTS, 0);
        Reset = 1'b0;
        @(negedge Clock);
        chk("rts_after_reset", RTS, 1);

        for (int i = 0; i < 4; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Bad second stop bit with the line then held low: BREAK until it returns high.
        run_vec(fe, "break");
        v0 = vcount;
        repeat (500) @(negedge Clock);
        chk("break_rts_held", RTS, 0);
        chk("break_no_repeat", vcount - v0, 0);
        RX_IN = 1'b1;
        repeat (5) @(negedge Clock);
        chk("break_rts_release", RTS, 1);

        // Glitch shorter than half a bit is rejected at the start sample.
        mode = 8'hB5;
        v0 = vcount;
        RX_IN = 1'b0;
        repeat (500) @(negedge Clock);
        chk("glitch_rts_busy", RTS, 0);
        RX_IN = 1'b1;
        repeat (1400) @(negedge Clock);
        chk("glitch_no_valid", vcount - v0, 0);
        chk("glitch_rts_idle", RTS, 1);
        chk("glitch_data_held", DATA, 8'h80);

        // Reset mid-frame after D4.
        mode = 8'hF5;
        v0 = vcount;
        RX_IN = 1'b0;
        repeat (869) @(negedge Clock);
        for (int i = 7; i >= 4; i--) begin
            RX_IN = v5a.byte_v[i];
            repeat (869) @(negedge Clock);
        end
        Reset = 1'b1;
        @(negedge Clock);
        chk("midreset_data", DATA, 8'h00);
        chk("midreset_frame_err", FRAME_ERR, 0);
        chk("midreset_parity_err", PARITY_ERR, 0);
        chk("midreset_valid", DATA_VALID, 0);
        chk("midreset_rts", RTS, 0);
        RX_IN = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        chk("midreset_rts_rearm", RTS, 1);
        repeat (900) @(negedge Clock);
        chk("midreset_no_valid", vcount - v0, 0);

        run_vec(v5a, "after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
